// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - fetch stage handshake bundle: control, instruction memory and decode sides
interface inst_fetch_if #(
    parameter int ADDR_W = 16
);
    logic              i_start;
    logic              i_redirect;
    logic [31:0]       i_redirect_pc;

    logic              o_imem_req;
    logic [ADDR_W-1:0] o_imem_addr;
    logic              i_imem_ready;
    logic              i_imem_rvalid;
    logic [31:0]       i_imem_rdata;

    logic              o_inst_valid;
    logic [31:0]       o_inst;
    logic [31:0]       o_inst_pc;
    logic              i_inst_ready;

    modport master (
        input  i_start, i_redirect, i_redirect_pc,
        output o_imem_req, o_imem_addr,
        input  i_imem_ready, i_imem_rvalid, i_imem_rdata,
        output o_inst_valid, o_inst, o_inst_pc,
        input  i_inst_ready
    );

    modport slave (
        output i_start, i_redirect, i_redirect_pc,
        input  o_imem_req, o_imem_addr,
        output i_imem_ready, i_imem_rvalid, i_imem_rdata,
        input  o_inst_valid, o_inst, o_inst_pc,
        output i_inst_ready
    );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage with credit-limited prefetch FIFO and redirect drain
// Optional IFETCH_BYPASS_EN: a response arriving at an empty FIFO with a ready consumer skips the FIFO.
module inst_fetch #(
    parameter int          DEPTH  = 4,
    parameter int          ADDR_W = 16,
    parameter logic [31:0] RST_PC = 32'd0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    inst_fetch_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [31:0]    resp_pc_q, resp_pc_d;
    logic [CW-1:0]  outstanding_q, outstanding_d;
    logic [CW-1:0]  drop_q, drop_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [31:0]    data_mem_q [DEPTH];
    logic [31:0]    pc_mem_q   [DEPTH];

    logic           redirect_act;
    logic           issue_ok;
    logic           accept;
    logic           resp_cnt;
    logic           bypass;
    logic           push;
    logic           pop;
    logic           fifo_valid;
    logic [CW:0]    credit_used;
    logic [31:0]    idle_pc;

    always_comb begin
        redirect_act = bus.i_redirect && (state_q != S_IDLE);
        credit_used  = {1'b0, outstanding_q} + {1'b0, count_q};
        // Words in flight plus words buffered never exceed DEPTH, so every response has a slot.
        issue_ok     = (state_q == S_FETCH) && !bus.i_redirect && (credit_used < CREDIT_MAX);
        accept       = issue_ok && bus.i_imem_ready;
        resp_cnt     = bus.i_imem_rvalid && (outstanding_q != '0);
        fifo_valid   = (count_q != '0);
`ifdef IFETCH_BYPASS_EN
        bypass       = (state_q == S_FETCH) && !redirect_act && !fifo_valid &&
                       bus.i_imem_rvalid && bus.i_inst_ready;
`else
        bypass       = 1'b0;
`endif
        push         = (state_q == S_FETCH) && bus.i_imem_rvalid && !redirect_act && !bypass;
        pop          = fifo_valid && bus.i_inst_ready && !redirect_act;
        idle_pc      = bus.i_redirect ? bus.i_redirect_pc : fetch_pc_q;
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(resp_cnt);
        drop_d        = drop_q;
        count_d       = count_q + CW'(push) - CW'(pop);
        wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d      = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd1;
        end
        if (push || bypass) begin
            resp_pc_d = resp_pc_q + 32'd1;
        end
        if ((state_q == S_DRAIN) && resp_cnt && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                fetch_pc_d = idle_pc;
                resp_pc_d  = idle_pc;
                if (bus.i_start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_FETCH;
            end
            S_DRAIN: begin
                if (drop_d == '0) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Redirect wins: the response (if any) this cycle is already discounted from drop.
        if (redirect_act) begin
            fetch_pc_d = bus.i_redirect_pc;
            resp_pc_d  = bus.i_redirect_pc;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            drop_d     = outstanding_q - CW'(resp_cnt);
            state_d    = (outstanding_d != '0) ? S_DRAIN : S_FETCH;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            fetch_pc_q    <= RST_PC;
            resp_pc_q     <= RST_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= bus.i_imem_rdata;
            pc_mem_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

    always_comb begin
        bus.o_imem_req   = issue_ok;
        bus.o_imem_addr  = fetch_pc_q[ADDR_W-1:0];
        bus.o_inst_valid = fifo_valid;
        bus.o_inst       = fifo_valid ? data_mem_q[rd_ptr_q] : 32'h0;
        bus.o_inst_pc    = fifo_valid ? pc_mem_q[rd_ptr_q]   : 32'h0;
`ifdef IFETCH_BYPASS_EN
        if (bypass) begin
            bus.o_inst_valid = 1'b1;
            bus.o_inst       = bus.i_imem_rdata;
            bus.o_inst_pc    = resp_pc_q;
        end
`endif
    end
endmodule
